// File: rtl/i2c_master_ctrl.sv
// Single-master I2C sequencer: one command -> START, address+R/W, ACK check,
// one data byte (write or read), STOP, then a one-cycle response strobe.
// SCL/SDA are open-drain: *_oe = 1 pulls the line low.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | lines released, waiting for a command
// S_START | 4 quarters: SDA high for 2, SDA low for 2, SCL released
// S_ADDR  | 8 bit cells of {addr, rw}, MSB first
// S_AACK  | address ACK cell, SDA released and sampled
// S_DATA  | 8 bit cells: shift out wdata, or sample read data
// S_DACK  | write: sample target ACK; read: master NACK (SDA released)
// S_STOP  | 4 quarters ending with SDA rising while SCL is released
// S_DONE  | one cycle, rsp_valid high
module i2c_master_ctrl #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic       rsp_nack,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [2:0]       bit_q, bit_d;
    logic [6:0]       addr_q, addr_d;
    logic             rw_q, rw_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             nack_q, nack_d;
    logic             samp_q, samp_d;
    logic             rsp_nack_q, rsp_nack_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;

    logic             tick;
    logic [7:0]       addr_byte;

    assign tick      = (state_q != S_IDLE) && (state_q != S_DONE) && (div_q == DIV_LAST);
    assign addr_byte = {addr_q, rw_q};

    // State and datapath registers; reset drops any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            qtr_q       <= '0;
            bit_q       <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            nack_q      <= 1'b0;
            samp_q      <= 1'b0;
            rsp_nack_q  <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            nack_q      <= nack_d;
            samp_q      <= samp_d;
            rsp_nack_q  <= rsp_nack_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next-state logic: quarter divider, bit sequencing, sampling and response capture.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        qtr_d       = qtr_q;
        bit_d       = bit_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        nack_d      = nack_q;
        samp_d      = samp_q;
        rsp_nack_d  = rsp_nack_q;
        rsp_rdata_d = rsp_rdata_q;

        // Divider sits at 0 outside a transaction so the first quarter is full length.
        if ((state_q == S_IDLE) || (state_q == S_DONE) || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rw_d    = cmd_rw;
                    wdata_d = cmd_wdata;
                    qtr_d   = 2'd0;
                    bit_d   = 3'd7;
                    nack_d  = 1'b0;
                    rdata_d = 8'h00;
                    state_d = S_START;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    // SDA is sampled on the tick that ends Q2 (SCL high).
                    if (qtr_q == 2'd2) begin
                        samp_d = sda_i;
                        if (state_q == S_DATA && rw_q) begin
                            rdata_d = {rdata_q[6:0], sda_i};
                        end
                    end
                    if (qtr_q == 2'd3) begin
                        case (state_q)
                            S_START: begin
                                state_d = S_ADDR;
                                bit_d   = 3'd7;
                            end
                            S_ADDR: begin
                                if (bit_q == 3'd0) state_d = S_AACK;
                                else               bit_d   = bit_q - 3'd1;
                            end
                            S_AACK: begin
                                if (samp_q) begin
                                    nack_d  = 1'b1;
                                    state_d = S_STOP;
                                end else begin
                                    state_d = S_DATA;
                                    bit_d   = 3'd7;
                                end
                            end
                            S_DATA: begin
                                if (bit_q == 3'd0) state_d = S_DACK;
                                else               bit_d   = bit_q - 3'd1;
                            end
                            S_DACK: begin
                                if (!rw_q && samp_q) nack_d = 1'b1;
                                state_d = S_STOP;
                            end
                            S_STOP: begin
                                // rdata_q is still 0 for writes and address NACKs.
                                rsp_nack_d  = nack_q;
                                rsp_rdata_d = rdata_q;
                                state_d     = S_DONE;
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Pin drive decoded from state and quarter so reset releases the lines at once.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            S_START: sda_oe = qtr_q[1];
            S_ADDR: begin
                scl_oe = ~qtr_q[1];
                sda_oe = ~addr_byte[bit_q];
            end
            S_AACK, S_DACK: scl_oe = ~qtr_q[1];
            S_DATA: begin
                scl_oe = ~qtr_q[1];
                sda_oe = ~rw_q & ~wdata_q[bit_q];
            end
            S_STOP: begin
                scl_oe = (qtr_q == 2'd0);
                sda_oe = (qtr_q == 2'd0) || (qtr_q == 2'd1);
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_nack  = rsp_nack_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a behavioural I2C target watches the open-drain
// lines, ACKs address 0x1C, returns a chosen read byte and records every bit
// seen on the bus; each response is compared with a transaction-level model.
module tb_i2c_master_ctrl;

    localparam int         CLK_DIV = 4;
    localparam logic [6:0] SLV     = 7'h1C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_nack;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_i;

    logic       pull = 1'b0;
    assign sda_i = ~sda_oe & ~pull;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata),
        .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Target model and bus monitor, evaluated mid-cycle.
    bit         bits_q[$];
    int         starts = 0, stops = 0, rsp_cnt = 0, bcnt = 0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, scl_l, sda_l;
    logic       active = 1'b0, hit = 1'b0, srw = 1'b0, pend_v = 1'b0, pend = 1'b0;
    logic [7:0] sh = '0, wsh = '0, rd_byte = '0, slave_wr = '0;
    logic       nack_data = 1'b0;

    always @(negedge clk) begin
        scl_l = ~scl_oe;
        sda_l = ~sda_oe & ~pull;
        if (rsp_valid) rsp_cnt++;
        if (prev_scl && scl_l && prev_sda && !sda_l) begin
            starts++; active = 1'b1; bcnt = 0; sh = '0; wsh = '0; pull = 1'b0; pend = 1'b0;
        end else if (prev_scl && scl_l && !prev_sda && sda_l) begin
            stops++; active = 1'b0; pull = 1'b0; pend = 1'b0;
        end else if (!prev_scl && scl_l) begin
            pend_v = sda_l; pend = 1'b1;
            if (active) begin
                bcnt++;
                if (bcnt <= 8) sh = {sh[6:0], sda_l};
                if (bcnt == 8) begin hit = (sh[7:1] == SLV); srw = sh[0]; end
                if (bcnt >= 10 && bcnt <= 17) wsh = {wsh[6:0], sda_l};
                if (bcnt == 17 && hit && !srw) slave_wr = wsh;
            end
        end else if (prev_scl && !scl_l) begin
            if (pend) bits_q.push_back(pend_v);
            pend = 1'b0;
            if (active) begin
                if (bcnt == 8)                                 pull = hit;
                else if (bcnt >= 9 && bcnt <= 16 && hit && srw) pull = ~rd_byte[3'(16 - bcnt)];
                else if (bcnt == 17 && hit && !srw)            pull = ~nack_data;
                else                                           pull = 1'b0;
            end
        end
        prev_scl = scl_l;
        prev_sda = sda_l;
    end

    int last_acc = 0, last_rsp = 0;

    // Issue one command, wait for its response and compare against the model.
    task automatic run_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                           input logic [7:0] rb, input logic nd, input bit hold, input bit intrude);
        int         base, st0, sp0, lat, expn, gotn;
        bit         got;
        bit         exp_q[$];
        logic       hitm, exp_nack;
        logic [7:0] exp_rdata, dbyte;
        logic [17:0] expv, gotv;
        rd_byte = rb; nack_data = nd;
        cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (cmd_ready) got = 1'b1;
            @(negedge clk);
        end
        check("accept", 32'(got), 32'(1));
        last_acc = cyc;
        base = bits_q.size(); st0 = starts; sp0 = stops;
        if (!hold) cmd_valid = 1'b0;
        check("busy_after_accept", 32'({busy, cmd_ready}), 32'(2'b10));
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin got = 1'b1; break; end
            if (intrude && i == 100) begin
                cmd_addr = ~a; cmd_rw = ~rw; cmd_wdata = ~wd; cmd_valid = 1'b1;
            end
            if (intrude && i == 101) begin
                check("ignored_while_busy", 32'({busy, cmd_ready}), 32'(2'b10));
                cmd_valid = hold; cmd_addr = a; cmd_rw = rw; cmd_wdata = wd;
            end
            @(negedge clk);
        end
        check("rsp_seen", 32'(got), 32'(1));
        lat = cyc - last_acc;
        last_rsp = cyc;

        hitm      = (a == SLV);
        exp_nack  = !hitm || (!rw && nd);
        exp_rdata = (hitm && rw) ? rb : 8'h00;
        for (int i = 6; i >= 0; i--) exp_q.push_back(a[i]);
        exp_q.push_back(rw);
        exp_q.push_back(!hitm);
        if (hitm) begin
            dbyte = rw ? rb : wd;
            for (int i = 7; i >= 0; i--) exp_q.push_back(dbyte[i]);
            exp_q.push_back(rw ? 1'b1 : nd);
        end
        expn = exp_q.size();
        gotn = bits_q.size() - base;
        expv = '0; gotv = '0;
        for (int i = 0; i < expn; i++) begin
            expv[i] = exp_q[i];
            if (i < gotn) gotv[i] = bits_q[base + i];
        end

        check("latency", 32'(lat), 32'((hitm ? 80 : 44) * CLK_DIV));
        check("rsp_nack", 32'(rsp_nack), 32'(exp_nack));
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
        check("bus_bit_count", 32'(gotn), 32'(expn));
        check("bus_bits", 32'(gotv), 32'(expv));
        check("start_count", 32'(starts - st0), 32'(1));
        check("stop_count", 32'(stops - sp0), 32'(1));
        if (hitm && !rw) check("target_wdata", 32'(slave_wr), 32'(wd));
        @(negedge clk);
        check("post_rsp", 32'({rsp_valid, cmd_ready, busy}), 32'(3'b010));
    endtask

    initial begin
        int b2b_rsp, rc0, stl;
        logic [6:0] ra;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({scl_oe, sda_oe, cmd_ready, busy, rsp_valid, rsp_nack, rsp_rdata}),
              32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_cmd(SLV, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
        run_cmd(7'h2A, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);
        run_cmd(SLV, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0);
        run_cmd(SLV, 1'b0, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0);

        run_cmd(SLV, 1'b0, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0);
        b2b_rsp = last_rsp;
        run_cmd(SLV, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0);
        check("b2b_accept_gap", 32'(last_acc - b2b_rsp), 32'(2));

        run_cmd(SLV, 1'b0, 8'h6E, 8'h00, 1'b0, 1'b0, 1'b1);

        for (int t = 0; t < 12; t++) begin
            ra = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV;
            run_cmd(ra, 1'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 5) == 0), 1'b0, 1'b0);
        end

        // Reset in the middle of data cell 3 of a write.
        cmd_addr = SLV; cmd_rw = 1'b0; cmd_wdata = 8'hF0; cmd_valid = 1'b1;
        stl = 0;
        while (!cmd_ready && stl < 50) begin @(negedge clk); stl++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (213) @(negedge clk);
        check("pre_reset_mid_data", 32'({busy, scl_oe}), 32'(2'b11));
        rc0 = rsp_cnt;
        rst_n = 1'b0;
        #1;
        check("async_reset_release", 32'({scl_oe, sda_oe, cmd_ready, busy}), 32'(4'b0010));
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("no_rsp_after_reset", 32'(rsp_cnt - rc0), 32'(0));
        run_cmd(SLV, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
